water_flow_monitor: RTL and testbench
=====================================

Name: water_flow_monitor

Overview:
- Responder on the washer controller's water-flow supervision interface.
- The controller drives water_flow_mode and water_flow_reset; this block watches water_level_sensor and returns water_flow_error when the level fails to move fast enough in the commanded direction.
- Fill mode requires the level to rise; drain mode requires it to fall. Progress is checked once per fixed-length window, and the error is raised after consecutive failed windows.

Parameters:
- LEVEL_W, 10, width of water_level_sensor.
- CHECK_CYCLES, 1000, length of one evaluation window in clk cycles (≥2).
- MIN_DELTA, 5, minimum level change per window for the window to pass.
- MAX_STRIKES, 2, number of consecutive failed windows that raises the error (≥1).
- STRIKE_W, $clog2(MAX_STRIKES+1), width of strike_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- water_flow_reset  in  1  1 = monitor disabled/cleared; 0 = monitor enabled.
- water_flow_mode  in  1  1 = fill, 0 = drain. Ignored (may be X) while water_flow_reset = 1.
- water_level_sensor  in  LEVEL_W  current water level.
- water_flow_error  out  1  sticky error flag.
- strike_count  out  STRIKE_W  number of consecutive failed windows.
- window_done  out  1  one-cycle strobe on each window evaluation.
- monitor_active  out  1  1 while in WINDOW state.

Behaviour:
- One clock domain; reset is synchronous and active-high. All outputs and state are registered.
- Reset values: state = IDLE; water_flow_error = 0; strike_count = 0; window_done = 0; monitor_active = 0; counter = 0; baseline = 0; mode_q = 0.
- Reset mid-window returns to IDLE at the next edge and overrides all other inputs.
- FSM states: IDLE, WINDOW, ERROR.
- IDLE:
  - While water_flow_reset = 1: hold all outputs at their reset values.
  - At an edge with water_flow_reset = 0 (the "arm edge"): baseline <= water_level_sensor; mode_q <= water_flow_mode; counter <= 0; state <= WINDOW.
- WINDOW:
  - counter increments at each edge.
  - At the edge where counter == CHECK_CYCLES-1, evaluate the window:
    - Fill progress = sensor − baseline if sensor > baseline, else 0.
    - Drain progress = baseline − sensor if baseline > sensor, else 0.
    - Arithmetic is unsigned in LEVEL_W bits; no wrap is possible by construction.
  - Pass when any of these holds:
    - progress ≥ MIN_DELTA;
    - drain mode and sensor == 0 (already empty);
    - fill mode and sensor == all-ones (saturated).
  - On pass: strike_count <= 0.
  - On fail: strike_count <= strike_count+1. If strike_count+1 == MAX_STRIKES, state <= ERROR and water_flow_error <= 1.
  - On every evaluation, pass or fail: window_done = 1 for that cycle, baseline <= sensor, counter <= 0.
  - Mode change: if water_flow_mode != mode_q at any WINDOW edge, restart as from the arm edge: rebaseline, counter = 0, strike_count = 0, mode_q updated. No evaluation occurs on that edge.
- ERROR:
  - water_flow_error held at 1; counter frozen; monitor_active = 0.
  - Leaves only on water_flow_reset = 1 or reset.
- water_flow_reset = 1 in any state: at the next edge, go to IDLE and clear water_flow_error, strike_count and counter. This takes priority over a simultaneous evaluation.
- Latency from the arm edge (edge 0):
  - First evaluation at edge CHECK_CYCLES.
  - Earliest error is visible in the cycle after edge MAX_STRIKES×CHECK_CYCLES.
- water_flow_error is a level signal. The controller latches it on its own side; this block does not pulse it.

Decomposition:
- Shared package washer_pkg holds:
  - FLOW_FILL = 1'b1 and FLOW_DRAIN = 1'b0;
  - LEVEL_W = 10;
  - the monitor state enum {MON_IDLE, MON_WINDOW, MON_ERROR}.
- One sub-module, flow_window_timer: a counter with clear/enable inputs and a terminal-count strobe at CHECK_CYCLES-1, parameterised by CHECK_CYCLES.
- Progress compare and strike logic stay in the top module.

Test Plan:
All scenarios use CHECK_CYCLES=8, MIN_DELTA=5, MAX_STRIKES=2.
1. Healthy fill: arm with mode = 1, level 0, then +1 per cycle. Each window_done sees progress 8; strike_count stays 0 and water_flow_error stays 0 for 40 cycles.
2. Stuck fill: arm at level 50, hold 50. strike_count = 1 after edge 8; water_flow_error = 1 in the cycle after edge 16; monitor_active = 0 and the error stays 1 for 20 more cycles.
3. Drain to empty: mode = 0, level 3, held at 0 after edge 2. The window passes via the empty exemption; strike_count = 0 and no error.
4. Recovery: one failed window (strike 1), then level +6 in the next window. strike_count returns to 0 and no error is raised.
5. Mode switch mid-window: fill for 5 cycles, then mode = 0. counter and strike_count clear and no window_done occurs that cycle; the next evaluation comes 8 edges after the switch.
6. Clear and resets:
   - In ERROR, pulse water_flow_reset = 1 for 1 cycle: water_flow_error = 0 next cycle, state IDLE, then re-arm on the following edge.
   - reset = 1 mid-window: all outputs 0 after the edge.

Source files
------------

// File: rtl/washer_pkg.sv
// Shared washer definitions: flow-mode encodings, level width and monitor state encoding.
package washer_pkg;

  localparam logic FLOW_FILL  = 1'b1;
  localparam logic FLOW_DRAIN = 1'b0;

  localparam int unsigned LEVEL_W = 10;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_WINDOW,
    MON_ERROR
  } mon_state_e;

endpackage

// File: rtl/flow_window_timer.sv
// Window-length counter: wraps at CHECK_CYCLES-1 and flags the terminal count.
module flow_window_timer #(
  parameter int unsigned CHECK_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam int unsigned CNT_W = $clog2(CHECK_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHECK_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last     = (r_count == LAST);
  assign o_terminal = w_last;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/water_flow_monitor.sv
// Water-flow supervisor: checks level progress per window in the commanded direction and
// raises a sticky error after MAX_STRIKES consecutive failed windows.
module water_flow_monitor
  import washer_pkg::*;
#(
  parameter int unsigned LEVEL_W      = washer_pkg::LEVEL_W,
  parameter int unsigned CHECK_CYCLES = 1000,
  parameter int unsigned MIN_DELTA    = 5,
  parameter int unsigned MAX_STRIKES  = 2,
  parameter int unsigned STRIKE_W     = $clog2(MAX_STRIKES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                water_flow_reset,
  input  logic                water_flow_mode,
  input  logic [LEVEL_W-1:0]  water_level_sensor,
  output logic                water_flow_error,
  output logic [STRIKE_W-1:0] strike_count,
  output logic                window_done,
  output logic                monitor_active
);

  mon_state_e          r_state, w_state_d;
  logic [LEVEL_W-1:0]  r_baseline, w_baseline_d;
  logic                r_mode, w_mode_d;
  logic                r_error, w_error_d;
  logic [STRIKE_W-1:0] r_strike, w_strike_d;
  logic                r_done, w_done_d;
  logic                r_active, w_active_d;

  logic                w_clear, w_enable, w_terminal, w_mode_change;
  logic [LEVEL_W-1:0]  w_fill_prog, w_drain_prog, w_progress;
  logic                w_pass;
  logic [STRIKE_W:0]   w_strike_inc;

  assign w_mode_change = (r_state == MON_WINDOW) && (water_flow_mode != r_mode);
  assign w_clear  = water_flow_reset || (r_state == MON_IDLE) || w_mode_change;
  assign w_enable = (r_state == MON_WINDOW);

  flow_window_timer #(
    .CHECK_CYCLES(CHECK_CYCLES)
  ) u_timer (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (w_clear),
    .i_enable  (w_enable),
    .o_terminal(w_terminal)
  );

  // Progress saturates at zero when the level moved the wrong way.
  assign w_fill_prog  = (water_level_sensor > r_baseline) ? water_level_sensor - r_baseline : '0;
  assign w_drain_prog = (r_baseline > water_level_sensor) ? r_baseline - water_level_sensor : '0;
  assign w_progress   = (r_mode == FLOW_FILL) ? w_fill_prog : w_drain_prog;

  assign w_pass = (w_progress >= LEVEL_W'(MIN_DELTA))
               || ((r_mode == FLOW_DRAIN) && (water_level_sensor == '0))
               || ((r_mode == FLOW_FILL) && (&water_level_sensor));

  assign w_strike_inc = {1'b0, r_strike} + 1'b1;

  always_comb begin
    w_state_d    = r_state;
    w_baseline_d = r_baseline;
    w_mode_d     = r_mode;
    w_error_d    = r_error;
    w_strike_d   = r_strike;
    w_done_d     = 1'b0;

    if (water_flow_reset) begin
      w_state_d  = MON_IDLE;
      w_error_d  = 1'b0;
      w_strike_d = '0;
    end else begin
      unique case (r_state)
        MON_IDLE: begin
          w_baseline_d = water_level_sensor;
          w_mode_d     = water_flow_mode;
          w_state_d    = MON_WINDOW;
        end
        MON_WINDOW: begin
          if (w_mode_change) begin
            w_baseline_d = water_level_sensor;
            w_mode_d     = water_flow_mode;
            w_strike_d   = '0;
          end else if (w_terminal) begin
            w_done_d     = 1'b1;
            w_baseline_d = water_level_sensor;
            if (w_pass) begin
              w_strike_d = '0;
            end else begin
              w_strike_d = w_strike_inc[STRIKE_W-1:0];
              if (w_strike_inc == (STRIKE_W + 1)'(MAX_STRIKES)) begin
                w_state_d = MON_ERROR;
                w_error_d = 1'b1;
              end
            end
          end
        end
        MON_ERROR: begin
        end
        default: w_state_d = MON_IDLE;
      endcase
    end

    w_active_d = (w_state_d == MON_WINDOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= MON_IDLE;
      r_baseline <= '0;
      r_mode     <= 1'b0;
      r_error    <= 1'b0;
      r_strike   <= '0;
      r_done     <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_baseline <= w_baseline_d;
      r_mode     <= w_mode_d;
      r_error    <= w_error_d;
      r_strike   <= w_strike_d;
      r_done     <= w_done_d;
      r_active   <= w_active_d;
    end
  end

  assign water_flow_error = r_error;
  assign strike_count     = r_strike;
  assign window_done      = r_done;
  assign monitor_active   = r_active;

endmodule

// File: tb/tb_water_flow_monitor.sv
// Directed bench for water_flow_monitor with CHECK_CYCLES=8, MIN_DELTA=5, MAX_STRIKES=2.
module tb_water_flow_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       wfr;
  logic       mode;
  logic [9:0] level;
  logic       err;
  logic [1:0] strike;
  logic       done;
  logic       active;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       rearm;
    logic       mode;
    logic [9:0] arm_level;
    logic [9:0] level;
    logic [1:0] exp_strike;
    logic       exp_err;
  } vec_t;

  vec_t tbl [14];

  water_flow_monitor #(
    .LEVEL_W     (10),
    .CHECK_CYCLES(8),
    .MIN_DELTA   (5),
    .MAX_STRIKES (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .water_flow_reset  (wfr),
    .water_flow_mode   (mode),
    .water_level_sensor(level),
    .water_flow_error  (err),
    .strike_count      (strike),
    .window_done       (done),
    .monitor_active    (active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic arm(input logic m, input logic [9:0] lvl);
    wfr = 1'b1;
    tick();
    wfr   = 1'b0;
    mode  = m;
    level = lvl;
    tick();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 10'd100,  10'd108,  2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 10'd0,    10'd110,  2'd1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 10'd0,    10'd115,  2'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 10'd0,    10'd119,  2'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 10'd0,    10'd119,  2'd2, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 10'd200,  10'd190,  2'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 10'd0,    10'd186,  2'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 10'd0,    10'd200,  2'd2, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 10'd3,    10'd0,    2'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 10'd0,    10'd0,    2'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 10'd1021, 10'd1023, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 10'd0,    10'd1023, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 10'd0,    10'd1022, 2'd1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 10'd0,    10'd1023, 2'd0, 1'b0};

    reset = 1'b1;
    wfr   = 1'b1;
    mode  = 1'b0;
    level = '0;
    tick();
    tick();
    chk("reset_err", err, 0);
    chk("reset_strike", strike, 0);
    chk("reset_done", done, 0);
    chk("reset_active", active, 0);
    reset = 1'b0;
    tick();
    chk("idle_hold_active", active, 0);

    // Healthy fill: +1 per cycle, windows pass with progress 8.
    begin
      int pulses = 0;
      arm(1'b1, 10'd0);
      chk("healthy_armed", active, 1);
      for (int k = 1; k <= 40; k++) begin
        level = 10'(k);
        tick();
        if (done) pulses++;
        chk("healthy_strike", strike, 0);
        chk("healthy_err", err, 0);
      end
      chk("healthy_pulses", pulses, 5);
    end

    // Stuck fill at 50: strike after edge 8, error after edge 16.
    arm(1'b1, 10'd50);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 8) begin
        chk("stuck_done8", done, 1);
        chk("stuck_strike8", strike, 1);
      end
      if (k == 15) chk("stuck_err15", err, 0);
    end
    chk("stuck_err16", err, 1);
    chk("stuck_strike16", strike, 2);
    chk("stuck_active16", active, 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("stuck_err_hold", err, 1);
      chk("stuck_done_hold", done, 0);
    end

    // One-cycle clear from ERROR, then re-arm on the following edge.
    wfr = 1'b1;
    tick();
    wfr = 1'b0;
    chk("clear_err", err, 0);
    chk("clear_strike", strike, 0);
    chk("clear_active", active, 0);
    tick();
    chk("rearm_active", active, 1);

    // Mode switch mid-window clears the strike and restarts the window.
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 8) chk("sw_strike8", strike, 1);
    end
    mode = 1'b0;
    tick();
    chk("sw_done", done, 0);
    chk("sw_strike", strike, 0);
    chk("sw_active", active, 1);
    for (int k = 13; k <= 19; k++) begin
      tick();
      chk("sw_no_eval", done, 0);
    end
    tick();
    chk("sw_eval_done", done, 1);
    chk("sw_eval_strike", strike, 1);

    // Clear wins over an evaluation that would have raised the error.
    for (int k = 21; k <= 27; k++) tick();
    wfr = 1'b1;
    tick();
    chk("prio_err", err, 0);
    chk("prio_strike", strike, 0);
    chk("prio_done", done, 0);
    chk("prio_active", active, 0);

    // Drain to empty passes via the empty exemption.
    wfr   = 1'b0;
    mode  = 1'b0;
    level = 10'd3;
    tick();
    tick();
    tick();
    level = 10'd0;
    for (int k = 3; k <= 8; k++) tick();
    chk("empty_done", done, 1);
    chk("empty_strike", strike, 0);
    chk("empty_err", err, 0);

    // Synchronous reset mid-window.
    arm(1'b1, 10'd500);
    for (int k = 1; k <= 8; k++) tick();
    chk("rst_pre_strike", strike, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_err", err, 0);
    chk("rst_strike", strike, 0);
    chk("rst_done", done, 0);
    chk("rst_active", active, 0);
    tick();
    chk("rst_hold_active", active, 0);
    reset = 1'b0;
    tick();
    chk("rst_rearm_active", active, 1);

    // Window-outcome table: each row is one full window after an optional re-arm.
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rearm) begin
        wfr = 1'b1;
        tick();
        chk("tbl_clear_err", err, 0);
        chk("tbl_clear_strike", strike, 0);
        wfr   = 1'b0;
        mode  = tbl[i].mode;
        level = tbl[i].arm_level;
        tick();
        chk("tbl_armed", active, 1);
      end
      level = tbl[i].level;
      repeat (7) tick();
      chk($sformatf("tbl%0d_pre_done", i), done, 0);
      tick();
      chk($sformatf("tbl%0d_done", i), done, 1);
      chk($sformatf("tbl%0d_strike", i), strike, tbl[i].exp_strike);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
      chk($sformatf("tbl%0d_active", i), active, !tbl[i].exp_err);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
